// File: rtl/hwpe_stream_package.sv
// rtl/hwpe_stream_package.sv - shared control/flag types for the linear stream sink
//
// Purpose : control and status structs plus the FSM state type used by
//           hwpe_stream_sink_linear.
// Contents: ctrl_sink_linear_t  - start request, base address, byte stride, beat count
//           flags_sink_linear_t - ready_start, done, in_progress, beat counter
//           sink_linear_state_e - IDLE / WORKING
package hwpe_stream_package;

  typedef struct packed {
    logic        req_start;
    logic [31:0] base_addr;
    logic [31:0] stride;
    logic [15:0] trans_size;
  } ctrl_sink_linear_t;

  typedef struct packed {
    logic        ready_start;
    logic        done;
    logic        in_progress;
    logic [15:0] beat_cnt;
  } flags_sink_linear_t;

  typedef enum logic {
    IDLE    = 1'b0,
    WORKING = 1'b1
  } sink_linear_state_e;

endpackage

// File: rtl/hwpe_stream_interfaces.sv
// rtl/hwpe_stream_interfaces.sv - stream and TCDM interfaces
//
// Purpose : hwpe_stream_intf_stream carries data beats (valid/ready/data/strb);
//           hwpe_stream_intf_tcdm is one 32-bit memory port (req/gnt/add/wen/be/data,
//           r_valid/r_data response).
// Modports: stream source/sink, tcdm master/slave.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

interface hwpe_stream_intf_tcdm ();
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (output req, output add, output wen, output be, output data,
                  input gnt, input r_data, input r_valid);
  modport slave  (input req, input add, input wen, input be, input data,
                  output gnt, output r_data, output r_valid);
endinterface

// File: rtl/hwpe_stream_sink_linear.sv
// rtl/hwpe_stream_sink_linear.sv - writes a stream of beats to linear TCDM addresses
//
// Purpose : each accepted stream beat is split into NB_TCDM_PORTS 32-bit words and
//           written to cur_addr + 4*ii; cur_addr advances by stride per beat.
// Ports   : clk_i, rst_ni (async, active low), test_mode_i (no effect),
//           clear_i (sync clear), stream (sink of beats), tcdm[] (write masters),
//           ctrl_i (start/base/stride/size), flags_o (status).
module hwpe_stream_sink_linear
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NB_TCDM_PORTS = DATA_WIDTH/32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 test_mode_i,
  input  logic                 clear_i,
  hwpe_stream_intf_stream.sink stream,
  hwpe_stream_intf_tcdm.master tcdm [NB_TCDM_PORTS-1:0],
  input  ctrl_sink_linear_t    ctrl_i,
  output flags_sink_linear_t   flags_o
);

  sink_linear_state_e       r_cs;
  sink_linear_state_e       w_ns;
  logic [31:0]              r_cur_addr;
  logic [31:0]              r_stride;
  logic [15:0]              r_trans_size;
  logic [15:0]              r_beat_cnt;
  logic                     r_done;

  logic [NB_TCDM_PORTS-1:0] w_port_ok;
  logic                     w_working;
  logic                     w_ready;
  logic                     w_handshake;
  logic                     w_last_beat;
  logic                     w_start;
  logic                     w_start_empty;
  logic                     w_unused;

  assign w_unused = test_mode_i;

  assign w_working     = (r_cs == WORKING);
  // A port counts as done for the current beat once it is granted now or was
  // granted earlier (fenced); the beat is consumed when every port is done.
  assign w_ready       = w_working & (&w_port_ok);
  assign w_handshake   = stream.valid & w_ready;
  assign w_last_beat   = (r_beat_cnt == r_trans_size - 16'd1);
  assign w_start       = (r_cs == IDLE) & ctrl_i.req_start & (ctrl_i.trans_size != 16'd0);
  assign w_start_empty = (r_cs == IDLE) & ctrl_i.req_start & (ctrl_i.trans_size == 16'd0);

  assign stream.ready  = w_ready;

  for (genvar ii = 0; ii < NB_TCDM_PORTS; ii++) begin : gen_port
    logic r_fence;
    logic w_req;
    logic w_unused_resp;

    // Write responses carry no information for this block.
    assign w_unused_resp = tcdm[ii].r_valid ^ (^tcdm[ii].r_data);

    assign w_req         = w_working & stream.valid & ~r_fence;
    assign w_port_ok[ii] = tcdm[ii].gnt | r_fence;

    // Once a port has written its word of the current beat it stays quiet until
    // the remaining ports catch up, so no word is written twice.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_fence <= 1'b0;
      end else if (clear_i || w_handshake) begin
        r_fence <= 1'b0;
      end else if (w_req && tcdm[ii].gnt) begin
        r_fence <= 1'b1;
      end
    end

    assign tcdm[ii].req  = w_req;
    assign tcdm[ii].add  = r_cur_addr + 32'(ii * 4);
    assign tcdm[ii].wen  = 1'b0;
    assign tcdm[ii].data = stream.data[32*ii +: 32];
    assign tcdm[ii].be   = stream.strb[4*ii +: 4];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cs <= IDLE;
    end else if (clear_i) begin
      r_cs <= IDLE;
    end else begin
      r_cs <= w_ns;
    end
  end

  always_comb begin
    w_ns = r_cs;
    case (r_cs)
      IDLE:    if (w_start) w_ns = WORKING;
      WORKING: if (w_handshake && w_last_beat) w_ns = IDLE;
      default: w_ns = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cur_addr   <= 32'd0;
      r_stride     <= 32'd0;
      r_trans_size <= 16'd0;
      r_beat_cnt   <= 16'd0;
      r_done       <= 1'b0;
    end else if (clear_i) begin
      r_cur_addr   <= 32'd0;
      r_stride     <= 32'd0;
      r_trans_size <= 16'd0;
      r_beat_cnt   <= 16'd0;
      r_done       <= 1'b0;
    end else begin
      // An empty transfer completes immediately without leaving IDLE.
      r_done <= w_start_empty | (w_handshake & w_last_beat);
      if (w_start) begin
        r_cur_addr   <= ctrl_i.base_addr;
        r_stride     <= ctrl_i.stride;
        r_trans_size <= ctrl_i.trans_size;
        r_beat_cnt   <= 16'd0;
      end else if (w_handshake) begin
        r_cur_addr <= r_cur_addr + r_stride;
        r_beat_cnt <= w_last_beat ? 16'd0 : r_beat_cnt + 16'd1;
      end
    end
  end

  assign flags_o.ready_start = (r_cs == IDLE);
  assign flags_o.in_progress = w_working;
  assign flags_o.done        = r_done;
  assign flags_o.beat_cnt    = r_beat_cnt;

endmodule

// File: tb/tb_hwpe_stream_sink_linear.sv
// tb/tb_hwpe_stream_sink_linear.sv - self-checking bench for hwpe_stream_sink_linear
module tb_hwpe_stream_sink_linear;
  import hwpe_stream_package::*;

  localparam int DW = 64;
  localparam int NP = 2;

  typedef struct packed {
    logic [31:0] add;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               test_mode;
  logic               clear;
  ctrl_sink_linear_t  ctrl;
  flags_sink_linear_t flags;

  logic [NP-1:0]      tb_gnt;
  logic [NP-1:0]      mon_req;
  logic [NP-1:0]      mon_wen;
  logic [31:0]        mon_add  [NP];
  logic [31:0]        mon_data [NP];
  logic [3:0]         mon_be   [NP];

  wr_t                exp_q0[$];
  wr_t                exp_q1[$];
  wr_t                mon_e;

  int                 n_vec = 0;
  int                 n_err = 0;

  always #5 clk = ~clk;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) s_if ();
  hwpe_stream_intf_tcdm t_if [NP-1:0] ();

  for (genvar g = 0; g < NP; g++) begin : gen_tcdm
    assign t_if[g].gnt     = tb_gnt[g];
    assign t_if[g].r_valid = 1'b1;
    assign t_if[g].r_data  = 32'hDEAD_BEE0 + 32'(g);
    assign mon_req[g]      = t_if[g].req;
    assign mon_wen[g]      = t_if[g].wen;
    assign mon_add[g]      = t_if[g].add;
    assign mon_data[g]     = t_if[g].data;
    assign mon_be[g]       = t_if[g].be;
  end

  hwpe_stream_sink_linear #(
    .DATA_WIDTH   (DW),
    .NB_TCDM_PORTS(NP)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .test_mode_i(test_mode),
    .clear_i    (clear),
    .stream     (s_if),
    .tcdm       (t_if),
    .ctrl_i     (ctrl),
    .flags_o    (flags)
  );

  // Every granted request is a committed write: pop and compare against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int g = 0; g < NP; g++) begin
        if (mon_req[g] && tb_gnt[g]) begin
          n_vec++;
          if ((g == 0 && exp_q0.size() == 0) || (g == 1 && exp_q1.size() == 0)) begin
            n_err++;
            $display("FAIL tcdm%0d_write: unexpected write add=%h data=%h be=%h, no write required",
                     g, mon_add[g], mon_data[g], mon_be[g]);
          end else begin
            if (g == 0) mon_e = exp_q0.pop_front();
            else        mon_e = exp_q1.pop_front();
            if (mon_add[g] !== mon_e.add || mon_data[g] !== mon_e.data ||
                mon_be[g] !== mon_e.be || mon_wen[g] !== 1'b0) begin
              n_err++;
              $display("FAIL tcdm%0d_write: got add=%h data=%h be=%h wen=%b, required add=%h data=%h be=%h wen=0",
                       g, mon_add[g], mon_data[g], mon_be[g], mon_wen[g], mon_e.add, mon_e.data, mon_e.be);
            end
          end
        end
      end
    end
  end

  task automatic push_port(input int p, input logic [31:0] add, input logic [31:0] d, input logic [3:0] be);
    wr_t w;
    w.add  = add;
    w.data = d;
    w.be   = be;
    if (p == 0) exp_q0.push_back(w);
    else        exp_q1.push_back(w);
  endtask

  task automatic start_xfer(input logic [31:0] base, input logic [31:0] stride, input logic [15:0] size);
    ctrl.req_start  = 1'b1;
    ctrl.base_addr  = base;
    ctrl.stride     = stride;
    ctrl.trans_size = size;
    @(posedge clk); #1;
    // Later ctrl changes must not affect the running transfer.
    ctrl.req_start  = 1'b0;
    ctrl.base_addr  = 32'hBAD0_0000;
    ctrl.stride     = 32'h0000_0044;
    ctrl.trans_size = 16'd7;
  endtask

  // Presents one beat, records the two expected word writes and waits for the handshake.
  task automatic drive_beat(input logic [31:0] add, input logic [63:0] d, input logic [7:0] s);
    int k;
    push_port(0, add,         d[31:0],  s[3:0]);
    push_port(1, add + 32'd4, d[63:32], s[7:4]);
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.strb  = s;
    k = 0;
    @(negedge clk);
    while (s_if.ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (s_if.ready !== 1'b1) begin
      n_err++;
      $display("FAIL beat_handshake: ready=%b after %0d cycles, required 1", s_if.ready, k);
    end
    @(posedge clk); #1;
    s_if.valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    s_if.valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (flags.ready_start !== 1'b1 || flags.done !== 1'b0 || flags.in_progress !== 1'b0 ||
        flags.beat_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_flags: got rs=%b done=%b ip=%b cnt=%0d, required 1 0 0 0",
               flags.ready_start, flags.done, flags.in_progress, flags.beat_cnt);
    end
    @(negedge clk);
    n_vec++;
    if (s_if.ready !== 1'b0 || mon_req !== 2'b00) begin
      n_err++;
      $display("FAIL reset_idle_outputs: got ready=%b req=%b, required 0 00", s_if.ready, mon_req);
    end
    @(posedge clk); #1;
    s_if.valid = 1'b0;
  endtask

  task automatic test_linear;
    logic [63:0] d;
    start_xfer(32'h0000_1000, 32'd8, 16'd4);
    n_vec++;
    if (flags.in_progress !== 1'b1 || flags.ready_start !== 1'b0) begin
      n_err++;
      $display("FAIL linear_start: got ip=%b rs=%b, required 1 0", flags.in_progress, flags.ready_start);
    end
    for (int k = 0; k < 4; k++) begin
      d = {$urandom, $urandom};
      drive_beat(32'h0000_1000 + 32'(k * 8), d, 8'hFF);
      n_vec++;
      if (k < 3) begin
        if (flags.beat_cnt !== 16'(k + 1) || flags.done !== 1'b0) begin
          n_err++;
          $display("FAIL linear_beat%0d: got cnt=%0d done=%b, required cnt=%0d done=0",
                   k, flags.beat_cnt, flags.done, k + 1);
        end
      end else begin
        if (flags.done !== 1'b1 || flags.beat_cnt !== 16'd0 || flags.in_progress !== 1'b0) begin
          n_err++;
          $display("FAIL linear_done: got done=%b cnt=%0d ip=%b, required 1 0 0",
                   flags.done, flags.beat_cnt, flags.in_progress);
        end
      end
    end
    @(posedge clk); #1;
    n_vec++;
    if (flags.done !== 1'b0) begin
      n_err++;
      $display("FAIL linear_done_width: got done=%b one cycle later, required 0", flags.done);
    end
    n_vec++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_err++;
      $display("FAIL linear_writes: %0d/%0d writes missing, required 0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic test_fence;
    logic [63:0] d;
    d = 64'hA5A5_0001_5A5A_0000;
    tb_gnt = 2'b01;
    start_xfer(32'h0000_3000, 32'd8, 16'd1);
    push_port(0, 32'h0000_3000, d[31:0],  4'hF);
    push_port(1, 32'h0000_3004, d[63:32], 4'hF);
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.strb  = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (mon_req[0] !== (c == 0) || mon_req[1] !== 1'b1 || s_if.ready !== 1'b0) begin
        n_err++;
        $display("FAIL fence_wait%0d: got req0=%b req1=%b ready=%b, required %0d 1 0",
                 c, mon_req[0], mon_req[1], s_if.ready, (c == 0));
      end
      @(posedge clk); #1;
    end
    tb_gnt = 2'b11;
    @(negedge clk);
    n_vec++;
    if (mon_req[0] !== 1'b0 || mon_req[1] !== 1'b1 || s_if.ready !== 1'b1) begin
      n_err++;
      $display("FAIL fence_release: got req0=%b req1=%b ready=%b, required 0 1 1",
               mon_req[0], mon_req[1], s_if.ready);
    end
    @(posedge clk); #1;
    s_if.valid = 1'b0;
    n_vec++;
    if (flags.done !== 1'b1 || exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_err++;
      $display("FAIL fence_end: got done=%b missing=%0d/%0d, required done=1 missing=0/0",
               flags.done, exp_q0.size(), exp_q1.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_strb;
    logic [63:0] d;
    d = 64'h1111_2222_3333_4444;
    start_xfer(32'h0000_4000, 32'd0, 16'd2);
    push_port(0, 32'h0000_4000, d[31:0],  4'hF);
    push_port(1, 32'h0000_4004, d[63:32], 4'h0);
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.strb  = 8'h0F;
    @(negedge clk);
    n_vec++;
    if (mon_be[0] !== 4'hF || mon_be[1] !== 4'h0) begin
      n_err++;
      $display("FAIL strb_split: got be0=%h be1=%h, required F 0", mon_be[0], mon_be[1]);
    end
    @(posedge clk); #1;
    s_if.valid = 1'b0;
    // Zero stride: the second beat lands on the same addresses.
    drive_beat(32'h0000_4000, 64'h5555_6666_7777_8888, 8'hF0);
    n_vec++;
    if (flags.done !== 1'b1 || exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_err++;
      $display("FAIL strb_end: got done=%b missing=%0d/%0d, required done=1 missing=0/0",
               flags.done, exp_q0.size(), exp_q1.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_size;
    ctrl.req_start  = 1'b1;
    ctrl.base_addr  = 32'h0000_5000;
    ctrl.stride     = 32'd8;
    ctrl.trans_size = 16'd0;
    s_if.valid = 1'b1;
    s_if.strb  = 8'hFF;
    @(negedge clk);
    n_vec++;
    if (mon_req !== 2'b00 || flags.done !== 1'b0) begin
      n_err++;
      $display("FAIL zero_start: got req=%b done=%b, required 00 0", mon_req, flags.done);
    end
    @(posedge clk); #1;
    ctrl.req_start = 1'b0;
    n_vec++;
    if (flags.done !== 1'b1 || flags.ready_start !== 1'b1 || flags.in_progress !== 1'b0) begin
      n_err++;
      $display("FAIL zero_done: got done=%b rs=%b ip=%b, required 1 1 0",
               flags.done, flags.ready_start, flags.in_progress);
    end
    @(negedge clk);
    n_vec++;
    if (mon_req !== 2'b00) begin
      n_err++;
      $display("FAIL zero_noreq: got req=%b, required 00", mon_req);
    end
    @(posedge clk); #1;
    n_vec++;
    if (flags.done !== 1'b0) begin
      n_err++;
      $display("FAIL zero_done_width: got done=%b, required 0", flags.done);
    end
    s_if.valid = 1'b0;
  endtask

  task automatic test_clear;
    logic [63:0] d;
    start_xfer(32'h0000_1800, 32'h10, 16'd5);
    drive_beat(32'h0000_1800, {$urandom, $urandom}, 8'hFF);
    drive_beat(32'h0000_1810, {$urandom, $urandom}, 8'hFF);
    // Third beat is left half-written: port 0 granted, port 1 stalled.
    d = {$urandom, $urandom};
    tb_gnt = 2'b01;
    push_port(0, 32'h0000_1820, d[31:0], 4'hF);
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.strb  = 8'hFF;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    s_if.valid = 1'b0;
    tb_gnt = 2'b11;
    n_vec++;
    if (flags.in_progress !== 1'b0 || flags.ready_start !== 1'b1 || flags.beat_cnt !== 16'd0 ||
        flags.done !== 1'b0) begin
      n_err++;
      $display("FAIL clear_abort: got ip=%b rs=%b cnt=%0d done=%b, required 0 1 0 0",
               flags.in_progress, flags.ready_start, flags.beat_cnt, flags.done);
    end
    @(posedge clk); #1;
    n_vec++;
    if (flags.done !== 1'b0) begin
      n_err++;
      $display("FAIL clear_nodone: got done=%b, required 0", flags.done);
    end
    start_xfer(32'h0000_2000, 32'd8, 16'd2);
    drive_beat(32'h0000_2000, {$urandom, $urandom}, 8'hFF);
    drive_beat(32'h0000_2008, {$urandom, $urandom}, 8'hFF);
    n_vec++;
    if (flags.done !== 1'b1 || exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_err++;
      $display("FAIL clear_restart: got done=%b missing=%0d/%0d, required done=1 missing=0/0",
               flags.done, exp_q0.size(), exp_q1.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap;
    start_xfer(32'hFFFF_FFF8, 32'd8, 16'd2);
    drive_beat(32'hFFFF_FFF8, {$urandom, $urandom}, 8'hFF);
    drive_beat(32'h0000_0000, {$urandom, $urandom}, 8'hFF);
    n_vec++;
    if (flags.done !== 1'b1 || exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_err++;
      $display("FAIL wrap_end: got done=%b missing=%0d/%0d, required done=1 missing=0/0",
               flags.done, exp_q0.size(), exp_q1.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    test_mode  = 1'b0;
    clear      = 1'b0;
    ctrl       = '0;
    tb_gnt     = 2'b11;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.strb  = '0;
    test_reset();
    test_linear();
    test_fence();
    test_strb();
    test_zero_size();
    test_clear();
    test_wrap();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
